// File: rtl/bcd_down_timer.sv
// bcd_down_timer: cascadable multi-digit BCD countdown timer.
// A loaded decimal value is decremented once per enable tick while running,
// stopping at zero with a one-cycle done pulse. With AUTO_RELOAD set, the
// last loaded value is restored on the tick after expiry and counting goes on.
module bcd_down_timer #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                en,
  output logic [4*DIGITS-1:0] cnt,
  output logic                zero,
  output logic                done,
  output logic                running,
  output logic                bcd_err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           done_q, done_d;
  logic           bcd_err_q, bcd_err_d;

  logic [W-1:0]      load_clean;
  logic [DIGITS-1:0] digit_bad;
  logic [W-1:0]      cnt_dec;
  logic [DIGITS-1:0] borrow;
  logic              cnt_zero;
  logic              cnt_one;
  logic              expire;

  assign cnt_zero  = (cnt_q == '0);
  assign cnt_one   = (cnt_q == W'(1));
  assign borrow[0] = 1'b1;

  // Per-digit load clamping and ripple-borrow BCD decrement.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_bad[gi]          = (load_val[4*gi +: 4] > 4'd9);
      assign load_clean[4*gi +: 4]  = digit_bad[gi] ? 4'd9 : load_val[4*gi +: 4];
      // A borrowed-from zero digit wraps to 9 and passes the borrow upward;
      // digits above the highest borrow keep their value.
      assign cnt_dec[4*gi +: 4] = !borrow[gi]              ? cnt_q[4*gi +: 4] :
                                  (cnt_q[4*gi +: 4] == 4'd0) ? 4'd9 :
                                  (cnt_q[4*gi +: 4] - 4'd1);
      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (cnt_q[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  // Next-state logic: load > start > pause > en, with expiry raising done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    bcd_err_d = 1'b0;
    expire    = 1'b0;

    if (load) begin
      cnt_d     = load_clean;
      reload_d  = load_clean;
      state_d   = S_IDLE;
      bcd_err_d = |digit_bad;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cnt_zero) begin
              state_d = S_EXPIRED;
              expire  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            // Already running: start consumes the cycle, nothing changes.
            state_d = S_RUN;
          end else if (pause) begin
            state_d = S_IDLE;
          end else if (en) begin
            if (cnt_zero) begin
              // Only reachable with auto-reload, on the tick after expiry.
              if (AUTO_RELOAD && (reload_q != '0)) begin
                cnt_d = reload_q;
              end else begin
                expire = 1'b1;
                if (!AUTO_RELOAD) begin
                  state_d = S_EXPIRED;
                end
              end
            end else if (cnt_one) begin
              cnt_d  = '0;
              expire = 1'b1;
              if (!AUTO_RELOAD) begin
                state_d = S_EXPIRED;
              end
            end else begin
              cnt_d = cnt_dec;
            end
          end
        end
        S_EXPIRED: begin
          if (start) begin
            expire = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // done must never stay high for two cycles in a row.
    done_d = expire && !done_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign cnt     = cnt_q;
  assign zero    = cnt_zero;
  assign done    = done_q;
  assign running = (state_q == S_RUN);
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed scenarios plus a random
// run compared against an integer-valued behavioural model.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [11:0] load_val3 = 12'h000;

  logic [7:0]  cnt, cnta;
  logic [11:0] cnt3;
  logic        zero, done, running, bcd_err;
  logic        zero3, done3, running3, bcd_err3;
  logic        zeroa, donea, runninga, bcd_erra;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = main instance, 1 = auto-reload instance.
  int m_val[2];
  int m_rel[2];
  int m_st[2];   // 0 idle, 1 run, 2 expired
  bit m_done[2];
  bit m_err[2];

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .en(en), .cnt(cnt), .zero(zero), .done(done),
    .running(running), .bcd_err(bcd_err));

  bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val3), .start(start),
    .pause(pause), .en(en), .cnt(cnt3), .zero(zero3), .done(done3),
    .running(running3), .bcd_err(bcd_err3));

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_dut_ar (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .en(en), .cnt(cnta), .zero(zeroa), .done(donea),
    .running(runninga), .bcd_err(bcd_erra));

  function automatic logic [31:0] int2bcd(input int x);
    logic [31:0] r;
    int v;
    r = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal value of a 2-digit preset, each digit clamped to 9.
  function automatic int preset_value(input logic [7:0] lv);
    int d1, d0;
    d0 = int'(lv[3:0]);
    d1 = int'(lv[7:4]);
    if (d0 > 9) d0 = 9;
    if (d1 > 9) d1 = 9;
    return d1 * 10 + d0;
  endfunction

  task automatic model_step(input int k, input bit auto_rl);
    bit expire;
    expire = 1'b0;
    if (rst) begin
      m_val[k] = 0; m_rel[k] = 0; m_st[k] = 0; m_done[k] = 0; m_err[k] = 0;
      return;
    end
    m_err[k] = 1'b0;
    if (load) begin
      m_val[k] = preset_value(load_val);
      m_rel[k] = m_val[k];
      m_st[k]  = 0;
      m_err[k] = (load_val[3:0] > 4'd9) || (load_val[7:4] > 4'd9);
    end else if (m_st[k] == 0) begin
      if (start) begin
        if (m_val[k] == 0) begin
          m_st[k] = 2;
          expire  = 1'b1;
        end else begin
          m_st[k] = 1;
        end
      end
    end else if (m_st[k] == 1) begin
      if (start) begin
        m_st[k] = 1;
      end else if (pause) begin
        m_st[k] = 0;
      end else if (en) begin
        if (m_val[k] == 0) begin
          if (auto_rl && m_rel[k] != 0) m_val[k] = m_rel[k];
          else expire = 1'b1;
        end else begin
          m_val[k] = m_val[k] - 1;
          if (m_val[k] == 0) begin
            expire = 1'b1;
            if (!auto_rl) m_st[k] = 2;
          end
        end
      end
    end else begin
      if (start) expire = 1'b1;
    end
    m_done[k] = expire && !m_done[k];
  endtask

  task automatic clk_step();
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l, input logic [7:0] lv, input bit s,
                       input bit p, input bit e);
    rst = 1'b0; load = l; load_val = lv; start = s; pause = p; en = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_step();
    clk_step();
    n_checks++;
    if (cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h want 00", cnt); end
    n_checks++;
    if (running !== 1'b0 || done !== 1'b0 || bcd_err !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: got run=%b done=%b err=%b zero=%b want 0 0 0 1",
               running, done, bcd_err, zero);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1, 8'h37, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    n_checks++;
    if (running !== 1'b1 || cnt !== 8'h37) begin
      n_fail++; $display("FAIL midrst_pre: got run=%b cnt=%h want 1 37", running, cnt);
    end
    drive(0, 8'h00, 0, 0, 1); rst = 1'b1; clk_step();
    n_checks++;
    if (cnt !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: got cnt=%h run=%b done=%b want 00 0 0", cnt, running, done);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 0, 0, 1); clk_step();
      n_checks++;
      if (cnt !== 8'h00 || running !== 1'b0) begin
        n_fail++; $display("FAIL midrst_en: got cnt=%h run=%b want 00 0", cnt, running);
      end
    end
  endtask

  task automatic test_countdown();
    logic [31:0] exp_bcd;
    drive(1, 8'h12, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    for (int i = 11; i >= 0; i--) begin
      drive(0, 8'h00, 0, 0, 1); clk_step();
      exp_bcd = int2bcd(i);
      n_checks++;
      if (cnt !== exp_bcd[7:0] || done !== (i == 0)) begin
        n_fail++;
        $display("FAIL count12: got cnt=%h done=%b want %h %b", cnt, done, exp_bcd[7:0], (i == 0));
      end
    end
    n_checks++;
    if (running !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL count12_end: got run=%b zero=%b want 0 1", running, zero);
    end
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h00 || done !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL expired_hold: got cnt=%h done=%b run=%b want 00 0 0", cnt, done, running);
    end
  endtask

  task automatic test_multi_borrow();
    load_val3 = 12'h100;
    drive(1, 8'h00, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt3 !== 12'h099) begin n_fail++; $display("FAIL borrow100: got %h want 099", cnt3); end
    load_val3 = 12'h010;
    drive(1, 8'h00, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt3 !== 12'h009) begin n_fail++; $display("FAIL borrow010: got %h want 009", cnt3); end
    load_val3 = 12'h000;
  endtask

  task automatic test_pause();
    drive(1, 8'h05, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h04) begin n_fail++; $display("FAIL pause_en1: got %h want 04", cnt); end
    drive(0, 8'h00, 0, 1, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h04 || running !== 1'b0) begin
      n_fail++; $display("FAIL pause_hold: got cnt=%h run=%b want 04 0", cnt, running);
    end
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h04) begin n_fail++; $display("FAIL paused_en: got %h want 04", cnt); end
    drive(0, 8'h00, 1, 1, 0); clk_step();
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_over_pause: got run=%b want 1", running); end
    drive(0, 8'h00, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h03) begin n_fail++; $display("FAIL resume: got %h want 03", cnt); end
    drive(1, 8'h42, 0, 0, 1); clk_step();
    n_checks++;
    if (cnt !== 8'h42 || running !== 1'b0) begin
      n_fail++; $display("FAIL load_en: got cnt=%h run=%b want 42 0", cnt, running);
    end
  endtask

  task automatic test_bcd_err_and_zero_start();
    drive(1, 8'hA3, 0, 0, 0); clk_step();
    n_checks++;
    if (cnt !== 8'h93 || bcd_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_digit: got cnt=%h err=%b want 93 1", cnt, bcd_err);
    end
    drive(0, 8'h00, 0, 0, 0); clk_step();
    n_checks++;
    if (bcd_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", bcd_err); end
    drive(1, 8'h00, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    n_checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL zero_start: got done=%b run=%b want 1 0", done, running);
    end
    drive(0, 8'h00, 1, 0, 0); clk_step();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_back2back: got %b want 0", done); end
    drive(0, 8'h00, 1, 0, 0); clk_step();
    n_checks++;
    if (done !== 1'b1 || cnt !== 8'h00) begin
      n_fail++; $display("FAIL expired_restart: got done=%b cnt=%h want 1 00", done, cnt);
    end
    drive(0, 8'h00, 0, 0, 0); clk_step();
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_c [4];
    bit         exp_d [4];
    exp_c = '{8'h01, 8'h00, 8'h02, 8'h01};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive(1, 8'h02, 0, 0, 0); clk_step();
    drive(0, 8'h00, 1, 0, 0); clk_step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 0, 0, 1); clk_step();
      n_checks++;
      if (cnta !== exp_c[i] || donea !== exp_d[i] || runninga !== 1'b1) begin
        n_fail++;
        $display("FAIL autoreload[%0d]: got cnt=%h done=%b run=%b want %h %b 1",
                 i, cnta, donea, runninga, exp_c[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e0, e1;
    bit s;
    for (int n = 0; n < 400; n++) begin
      // start is only offered outside RUN, where its effect is unambiguous.
      s = ($urandom_range(0, 7) == 0) && (m_st[0] != 1) && (m_st[1] != 1);
      drive($urandom_range(0, 11) == 0, 8'($urandom_range(0, 255)), s,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
      clk_step();
      e0 = int2bcd(m_val[0]);
      e1 = int2bcd(m_val[1]);
      n_checks++;
      if (cnt !== e0[7:0] || done !== m_done[0] || running !== (m_st[0] == 1) ||
          bcd_err !== m_err[0] || zero !== (m_val[0] == 0)) begin
        n_fail++;
        $display("FAIL rand_main[%0d]: got cnt=%h d=%b r=%b e=%b z=%b want %h %b %b %b %b",
                 n, cnt, done, running, bcd_err, zero, e0[7:0], m_done[0],
                 (m_st[0] == 1), m_err[0], (m_val[0] == 0));
      end
      n_checks++;
      if (cnta !== e1[7:0] || donea !== m_done[1] || runninga !== (m_st[1] == 1) ||
          bcd_erra !== m_err[1]) begin
        n_fail++;
        $display("FAIL rand_auto[%0d]: got cnt=%h d=%b r=%b e=%b want %h %b %b %b",
                 n, cnta, donea, runninga, bcd_erra, e1[7:0], m_done[1],
                 (m_st[1] == 1), m_err[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_rel[k] = 0; m_st[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end
    #1;
    test_reset();
    test_reset_mid_run();
    test_countdown();
    test_multi_borrow();
    test_pause();
    test_bcd_err_and_zero_start();
    test_auto_reload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
